// File: rtl/framebuf_pkg.sv
// Shared widths and read-tag types for the frame-buffer port arbiter.
package framebuf_pkg;

  localparam int FB_ADDR_W = 14;
  localparam int FB_DATA_W = 16;
  localparam int FB_BE_W   = 2;

  typedef enum logic {OWN_A, OWN_B} fb_owner_t;

  typedef struct packed {
    logic      valid;
    fb_owner_t owner;
  } fb_tag_t;

  localparam fb_tag_t FB_TAG_NONE = '{valid: 1'b0, owner: OWN_A};

endpackage

// File: rtl/framebuf_port_arbiter_tag_pipe.sv
// fb_tag_pipe: fixed-depth shift register of read tags with synchronous clear.
module fb_tag_pipe
  import framebuf_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    clr,
  input  fb_tag_t tag_in,
  output fb_tag_t tag_out
);

  fb_tag_t [DEPTH-1:0] stage_q;
  fb_tag_t [DEPTH-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    if (clr) begin
      stage_d = {DEPTH{FB_TAG_NONE}};
    end
  end

  always_ff @(posedge clk) begin
    stage_q <= stage_d;
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/framebuf_port_arbiter.sv
// framebuf_port_arbiter: shares one frame-buffer RAM port between host (A) and scan-out (B).
// Optional A starvation guard is compiled in when FBARB_STARVE_GUARD_EN is defined.
module framebuf_port_arbiter
  import framebuf_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int MAX_WAIT     = 8
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 a_req,
  input  logic                 a_write,
  input  logic [FB_ADDR_W-1:0] a_addr,
  input  logic [FB_DATA_W-1:0] a_wdata,
  input  logic [FB_BE_W-1:0]   a_be,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [FB_DATA_W-1:0] a_rdata,
  input  logic                 b_req,
  input  logic [FB_ADDR_W-1:0] b_addr,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [FB_DATA_W-1:0] b_rdata,
  output logic [FB_ADDR_W-1:0] mem_address,
  output logic                 mem_chipselect,
  output logic                 mem_clken,
  output logic                 mem_write,
  output logic [FB_DATA_W-1:0] mem_writedata,
  output logic [FB_BE_W-1:0]   mem_byteenable,
  input  logic [FB_DATA_W-1:0] mem_readdata
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("framebuf_port_arbiter: READ_LATENCY must be 1..4");
  end
  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_wait
    $error("framebuf_port_arbiter: MAX_WAIT must be 1..255");
  end

  logic force_a;

`ifdef FBARB_STARVE_GUARD_EN
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_d;

  assign force_a = (wait_cnt_q == WAIT_MAX);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (a_gnt) begin
      wait_cnt_d = '0;
    end else if (a_req && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign force_a = 1'b0;
`endif

  // B wins contention unless the guard has saturated; nothing is granted in reset.
  assign b_gnt = !reset_reset && b_req && !force_a;
  assign a_gnt = !reset_reset && a_req && (!b_req || force_a);

  logic [FB_ADDR_W-1:0] mem_address_q,    mem_address_d;
  logic                 mem_chipselect_q, mem_chipselect_d;
  logic                 mem_write_q,      mem_write_d;
  logic [FB_DATA_W-1:0] mem_writedata_q,  mem_writedata_d;
  logic [FB_BE_W-1:0]   mem_byteenable_q, mem_byteenable_d;

  always_comb begin
    mem_chipselect_d = a_gnt || b_gnt;
    mem_write_d      = a_gnt && a_write;
    mem_address_d    = mem_address_q;
    mem_writedata_d  = mem_writedata_q;
    mem_byteenable_d = mem_byteenable_q;
    if (b_gnt) begin
      mem_address_d    = b_addr;
      mem_byteenable_d = '1;
    end else if (a_gnt) begin
      mem_address_d    = a_addr;
      mem_writedata_d  = a_wdata;
      mem_byteenable_d = a_be;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      mem_address_q    <= '0;
      mem_chipselect_q <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= '0;
      mem_byteenable_q <= '0;
    end else begin
      mem_address_q    <= mem_address_d;
      mem_chipselect_q <= mem_chipselect_d;
      mem_write_q      <= mem_write_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_chipselect = mem_chipselect_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign mem_clken      = 1'b1;

  // One extra stage covers the command register ahead of the RAM latency.
  fb_tag_t tag_in;
  fb_tag_t tag_out;

  always_comb begin
    tag_in.valid = b_gnt || (a_gnt && !a_write);
    tag_in.owner = b_gnt ? OWN_B : OWN_A;
  end

  fb_tag_pipe #(
    .DEPTH (READ_LATENCY + 1)
  ) u_tag_pipe (
    .clk     (clk_clk),
    .clr     (reset_reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign a_rvalid = tag_out.valid && (tag_out.owner == OWN_A);
  assign b_rvalid = tag_out.valid && (tag_out.owner == OWN_B);
  assign a_rdata  = mem_readdata;
  assign b_rdata  = mem_readdata;

endmodule

// File: tb/tb_framebuf_port_arbiter.sv
// Self-checking bench for framebuf_port_arbiter with a behavioural RAM and a scoreboard model.
// Guard expectations follow FBARB_STARVE_GUARD_EN.
module tb_framebuf_port_arbiter;

  localparam int RL = 2;
  localparam int MW = 8;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        a_req, a_write;
  logic [13:0] a_addr;
  logic [15:0] a_wdata;
  logic [1:0]  a_be;
  logic        a_gnt, a_rvalid;
  logic [15:0] a_rdata;
  logic        b_req;
  logic [13:0] b_addr;
  logic        b_gnt, b_rvalid;
  logic [15:0] b_rdata;
  logic [13:0] mem_address;
  logic        mem_chipselect, mem_clken, mem_write;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata;

  framebuf_port_arbiter #(.READ_LATENCY(RL), .MAX_WAIT(MW)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata)
  );

  always #5 clk_clk = ~clk_clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge_be(input logic [15:0] old, input logic [15:0] d,
                                           input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0] = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Behavioural RAM: registered command in, data out READ_LATENCY cycles later.
  logic [15:0] ram    [0:16383];
  logic [15:0] shadow [0:16383];
  logic [15:0] rd_pipe [RL];

  always @(posedge clk_clk) begin
    if (mem_chipselect && mem_write)
      ram[mem_address] <= merge_be(ram[mem_address], mem_writedata, mem_byteenable);
    if (mem_chipselect && !mem_write) rd_pipe[0] <= ram[mem_address];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_readdata = rd_pipe[RL-1];

  task automatic preload(input logic [13:0] ad, input logic [15:0] d);
    ram[ad] = d;
    shadow[ad] = d;
  endtask

  // Scoreboard: expected returns pushed at grant, popped when the DUT presents rvalid.
  typedef struct {
    logic        own_b;
    logic [15:0] data;
    int          due;
  } ret_t;
  ret_t q[$];

  int          wait_m = 0;
  bit          started = 0;
  logic        exp_cs, exp_wr;
  logic [13:0] exp_addr;
  logic [15:0] exp_wdata;
  logic [1:0]  exp_be;

  always @(negedge clk_clk) begin : mon
    logic ea, eb, frc;
    ret_t e;
    if (a_rvalid || b_rvalid) begin
      chk("rvalid_exclusive", {31'd0, a_rvalid & b_rvalid}, 0);
      if (q.size() == 0) begin
        chk("spurious_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
      end else begin
        e = q.pop_front();
        chk("ret_owner", {31'd0, b_rvalid}, {31'd0, e.own_b});
        chk("ret_data", {16'd0, b_rvalid ? b_rdata : a_rdata}, {16'd0, e.data});
        chk("ret_cycle", cyc, e.due);
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("missing_rvalid", {30'd0, a_rvalid, b_rvalid}, e.own_b ? 32'd1 : 32'd2);
    end

    if (started) begin
      chk("mem_chipselect", {31'd0, mem_chipselect}, {31'd0, exp_cs});
      chk("mem_write", {31'd0, mem_write}, {31'd0, exp_wr});
      chk("mem_address", {18'd0, mem_address}, {18'd0, exp_addr});
      chk("mem_writedata", {16'd0, mem_writedata}, {16'd0, exp_wdata});
      chk("mem_byteenable", {30'd0, mem_byteenable}, {30'd0, exp_be});
      chk("mem_clken", {31'd0, mem_clken}, 1);
    end

    if (reset_reset) begin
      chk("a_gnt_in_reset", {31'd0, a_gnt}, 0);
      chk("b_gnt_in_reset", {31'd0, b_gnt}, 0);
      q.delete();
      wait_m = 0;
      exp_cs = 0; exp_wr = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
      started = 1;
    end else begin
`ifdef FBARB_STARVE_GUARD_EN
      frc = (wait_m == MW);
`else
      frc = 1'b0;
`endif
      eb = b_req && !frc;
      ea = a_req && (!b_req || frc);
      chk("a_gnt", {31'd0, a_gnt}, {31'd0, ea});
      chk("b_gnt", {31'd0, b_gnt}, {31'd0, eb});
      exp_cs = ea || eb;
      exp_wr = ea && a_write;
      if (eb) begin
        exp_addr = b_addr; exp_be = 2'b11;
        q.push_back('{own_b: 1'b1, data: shadow[b_addr], due: cyc + 1 + RL});
      end else if (ea) begin
        exp_addr = a_addr; exp_wdata = a_wdata; exp_be = a_be;
        if (a_write) shadow[a_addr] = merge_be(shadow[a_addr], a_wdata, a_be);
        else q.push_back('{own_b: 1'b0, data: shadow[a_addr], due: cyc + 1 + RL});
      end
      if (ea) wait_m = 0;
      else if (a_req && wait_m < MW) wait_m++;
    end
  end

  task automatic issue(input bit is_b, input logic w, input logic [13:0] ad,
                       input logic [15:0] d, input logic [1:0] be, output int g);
    @(posedge clk_clk); #1;
    if (is_b) begin
      b_req = 1; b_addr = ad;
    end else begin
      a_req = 1; a_write = w; a_addr = ad; a_wdata = d; a_be = be;
    end
    g = -1;
    for (int k = 0; k < 50 && g < 0; k++) begin
      @(negedge clk_clk);
      if (is_b ? b_gnt : a_gnt) g = cyc;
    end
    if (g < 0) begin
      checks++; failures++;
      $display("FAIL issue_timeout actual=no_gnt required=gnt addr=0x%0h", ad);
    end
    @(posedge clk_clk); #1;
    if (is_b) b_req = 0; else a_req = 0;
  endtask

  task automatic expect_ret(input bit is_b, input logic [15:0] d, input int g);
    int got;
    got = -1;
    for (int k = 0; k < 8 && got < 0; k++) begin
      @(negedge clk_clk);
      if (a_rvalid || b_rvalid) begin
        got = cyc;
        chk("dir_b_rvalid", {31'd0, b_rvalid}, {31'd0, is_b});
        chk("dir_a_rvalid", {31'd0, a_rvalid}, {31'd0, !is_b});
        chk("dir_rdata", {16'd0, is_b ? b_rdata : a_rdata}, {16'd0, d});
        chk("dir_latency", cyc - g, RL + 1);
      end
    end
    if (got < 0) begin
      checks++; failures++;
      $display("FAIL dir_ret_timeout actual=no_rvalid required=rvalid data=0x%0h", d);
    end
  endtask

  initial begin
    int g, g0, k_gnt;
    bit ad, bd;
    for (int i = 0; i < 16384; i++) begin
      ram[i] = 16'(i * 40503) ^ 16'h5A5A;
      shadow[i] = ram[i];
    end
    for (int i = 0; i < RL; i++) rd_pipe[i] = '0;
    reset_reset = 1; a_req = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
    b_req = 0; b_addr = 0;
    repeat (3) @(posedge clk_clk);
    #1 reset_reset = 0;
    repeat (2) @(posedge clk_clk);

    // Write then read back at the top address.
    issue(0, 1, 14'h3FFF, 16'hBEEF, 2'b11, g);
    issue(0, 0, 14'h3FFF, 16'h0, 2'b00, g);
    expect_ret(0, 16'hBEEF, g);

    // Low-byte write, read back by B.
    preload(14'h0010, 16'h5555);
    issue(0, 1, 14'h0010, 16'h00AA, 2'b01, g);
    issue(1, 0, 14'h0010, 16'h0, 2'b00, g);
    expect_ret(1, 16'h55AA, g);

    // Back-to-back B, A, B interleave.
    preload(14'h0001, 16'h1111);
    preload(14'h0002, 16'h2222);
    preload(14'h0003, 16'h3333);
    repeat (4) @(posedge clk_clk);
    #1 b_req = 1; b_addr = 14'h0001; a_req = 1; a_write = 0; a_addr = 14'h0002;
    @(negedge clk_clk); g0 = cyc;
    chk("il_b0_gnt", {31'd0, b_gnt}, 1);
    @(posedge clk_clk); #1 b_req = 0;
    @(negedge clk_clk); chk("il_a_gnt", {31'd0, a_gnt}, 1);
    @(posedge clk_clk); #1 a_req = 0; b_req = 1; b_addr = 14'h0003;
    @(negedge clk_clk); chk("il_b1_gnt", {31'd0, b_gnt}, 1);
    @(posedge clk_clk); #1 b_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_clk);
      chk("il_cycle", cyc, g0 + RL + 1 + k);
      chk("il_b_rvalid", {31'd0, b_rvalid}, (k != 1) ? 32'd1 : 32'd0);
      chk("il_a_rvalid", {31'd0, a_rvalid}, (k == 1) ? 32'd1 : 32'd0);
      chk("il_data", {16'd0, mem_readdata}, (k == 0) ? 32'h1111 : (k == 1) ? 32'h2222 : 32'h3333);
    end

    // Contention: B requests every cycle while A waits.
    repeat (3) @(posedge clk_clk);
    #1 a_req = 1; a_write = 0; a_addr = 14'h0020; b_req = 1; b_addr = 14'h0021;
    k_gnt = 0;
    for (int k = 1; k <= 100 && k_gnt == 0; k++) begin
      @(negedge clk_clk);
      if (a_gnt) k_gnt = k;
    end
`ifdef FBARB_STARVE_GUARD_EN
    chk("starve_gnt_cycle", k_gnt, MW + 1);
    @(posedge clk_clk); #1 a_req = 0;
    @(negedge clk_clk);
    chk("starve_b_resumes", {31'd0, b_gnt}, 1);
    chk("starve_wait_clear", {24'd0, dut.wait_cnt_q}, 0);
    @(posedge clk_clk); #1 b_req = 0;
`else
    chk("starve_no_gnt", k_gnt, 0);
    @(posedge clk_clk); #1 b_req = 0;
    k_gnt = 0;
    for (int k = 1; k <= 5 && k_gnt == 0; k++) begin
      @(negedge clk_clk);
      if (a_gnt) k_gnt = k;
    end
    chk("starve_release_gnt", k_gnt, 1);
    @(posedge clk_clk); #1 a_req = 0;
`endif
    repeat (6) @(posedge clk_clk);

    // Reset while a read is in flight.
    preload(14'h0005, 16'h1234);
    issue(0, 0, 14'h0005, 16'h0, 2'b00, g);
    @(posedge clk_clk); #1 reset_reset = 1;
    @(posedge clk_clk); #1 reset_reset = 0;
    @(negedge clk_clk);
    chk("rst_mem_address", {18'd0, mem_address}, 0);
    chk("rst_mem_chipselect", {31'd0, mem_chipselect}, 0);
    chk("rst_mem_byteenable", {30'd0, mem_byteenable}, 0);
    for (int k = 0; k < 6; k++) begin
      chk("rst_no_a_rvalid", {31'd0, a_rvalid}, 0);
      @(negedge clk_clk);
    end

    // Randomised traffic over a small address window to exercise read-after-write.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_clk);
      ad = a_req && a_gnt;
      bd = b_req && b_gnt;
      @(posedge clk_clk); #1;
      if (!a_req || ad) begin
        a_req = ($urandom_range(0, 2) != 0);
        a_write = 1'($urandom_range(0, 1));
        a_addr = 14'($urandom_range(0, 15));
        a_wdata = 16'($urandom);
        a_be = 2'($urandom_range(0, 3));
      end
      if (!b_req || bd) begin
        b_req = ($urandom_range(0, 1) != 0);
        b_addr = 14'($urandom_range(0, 15));
      end
    end
    for (int k = 0; k < 200 && (a_req || b_req); k++) begin
      @(negedge clk_clk);
      ad = a_req && a_gnt;
      bd = b_req && b_gnt;
      @(posedge clk_clk); #1;
      if (ad) a_req = 0;
      if (bd) b_req = 0;
    end
    b_req = 0;
    a_req = 0;
    repeat (10) @(posedge clk_clk);
    @(negedge clk_clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
